// File: rtl/matmul_pkg.sv
// Shared constants and helpers for the matrix-multiply sequencing controller.
// State codes are plain 3-bit constants so legacy blocks can match on them directly.
package matmul_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_M          = 8;
  localparam int DEF_N          = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_MAC    = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;
  localparam logic [2:0] ST_READ_C = 3'd6;
  localparam logic [2:0] ST_FLUSH  = 3'd7;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 0; p < 31; p++) begin
      if ((32'sd1 << p) < value) begin
        r = p + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Counter width able to hold the given limit value itself.
  function automatic int cnt_w(input int limit);
    return clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/matmul_ctrl_if.sv
// Control bus between the matmul sequencer and its datapath / load source.
// master = sequencer side, slave = datapath and stimulus side.
interface matmul_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              m1EN, m1rEN, m1wEN;
  logic              m2EN, m2rEN, m2wEN;
  logic              m3EN, m3rEN, m3wEN;
  logic [ADDR_W-1:0] addr1, addr2, addr3;
  logic              mult_ld;
  logic              mult_rst;
  logic [1:0]        shift_cnt;
  logic              out_valid;
  logic              busy;
  logic              done;

  modport master (
    input  start, in_valid,
    output in_ready, m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN,
           addr1, addr2, addr3, mult_ld, mult_rst, shift_cnt, out_valid, busy, done
  );

  modport slave (
    output start, in_valid,
    input  in_ready, m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN,
           addr1, addr2, addr3, mult_ld, mult_rst, shift_cnt, out_valid, busy, done
  );
endinterface

// File: rtl/matmul_ctrl_idx_counter.sv
// Wrap counter: clears on clr_i, steps on inc_i, and returns to zero after max_i.
// wrap_o flags the stepping cycle that leaves max_i.
module idx_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count and wrap detection
  always_comb begin
    wrap_o = inc_i && (cnt_q == max_i);
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for C = A x B: streams A then B into memory, runs the MAC schedule,
// writes each C element, then streams C back out of the result memory.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int M          = DEF_M,
  parameter int N          = DEF_N,
  parameter int ADDR_W     = M + N
) (
  input logic           clk,
  input logic           rst,
  matmul_ctrl_if.master bus
);
  localparam int IJ_W    = cnt_w(M);
  localparam int K_W     = cnt_w(N);
  localparam int LIN_MAX = (M * N > M * M) ? M * N : M * M;
  localparam int LIN_W   = cnt_w(LIN_MAX);
  // The element width only matters to a shifting datapath; this schedule never shifts.
  localparam logic [1:0] SHIFT_NONE = (DATA_WIDTH > 0) ? 2'b00 : 2'b00;

  logic [2:0]       state_q, state_d;
  logic             mac_rd_q, rd_c_q, done_q;
  logic [LIN_W-1:0] lin_cnt, lin_max;
  logic [K_W-1:0]   k_cnt;
  logic [IJ_W-1:0]  i_cnt, j_cnt;
  logic             lin_wrap, k_wrap, j_wrap, i_wrap;
  logic             load_s, xfer_s, cnt_clr_s;
  logic             lin_inc_s, k_inc_s, j_inc_s, i_inc_s;

  assign load_s    = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign xfer_s    = load_s && bus.in_valid;
  assign cnt_clr_s = (state_q == ST_IDLE);
  assign lin_inc_s = xfer_s || (state_q == ST_READ_C);
  assign k_inc_s   = (state_q == ST_MAC);
  assign j_inc_s   = (state_q == ST_WRITE);
  assign i_inc_s   = (state_q == ST_WRITE) && j_wrap;
  assign lin_max   = (state_q == ST_READ_C) ? LIN_W'(M * M - 1) : LIN_W'(M * N - 1);

  idx_counter #(.W(LIN_W)) u_lin (.clk(clk), .rst(rst), .clr_i(cnt_clr_s), .inc_i(lin_inc_s),
                                  .max_i(lin_max), .cnt_o(lin_cnt), .wrap_o(lin_wrap));
  idx_counter #(.W(K_W)) u_k (.clk(clk), .rst(rst), .clr_i(cnt_clr_s), .inc_i(k_inc_s),
                              .max_i(K_W'(N - 1)), .cnt_o(k_cnt), .wrap_o(k_wrap));
  idx_counter #(.W(IJ_W)) u_j (.clk(clk), .rst(rst), .clr_i(cnt_clr_s), .inc_i(j_inc_s),
                               .max_i(IJ_W'(M - 1)), .cnt_o(j_cnt), .wrap_o(j_wrap));
  idx_counter #(.W(IJ_W)) u_i (.clk(clk), .rst(rst), .clr_i(cnt_clr_s), .inc_i(i_inc_s),
                               .max_i(IJ_W'(M - 1)), .cnt_o(i_cnt), .wrap_o(i_wrap));

  // Next state and per-state memory strobes
  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.m1EN     = 1'b0;
    bus.m1rEN    = 1'b0;
    bus.m1wEN    = 1'b0;
    bus.m2EN     = 1'b0;
    bus.m2rEN    = 1'b0;
    bus.m2wEN    = 1'b0;
    bus.m3EN     = 1'b0;
    bus.m3rEN    = 1'b0;
    bus.m3wEN    = 1'b0;
    bus.addr1    = '0;
    bus.addr2    = '0;
    bus.addr3    = '0;
    bus.mult_rst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_LOAD_A;
        else           state_d = ST_IDLE;
      end
      ST_LOAD_A: begin
        bus.in_ready = 1'b1;
        bus.m1EN     = xfer_s;
        bus.m1wEN    = xfer_s;
        bus.addr1    = ADDR_W'(lin_cnt);
        if (lin_wrap) state_d = ST_LOAD_B;
        else          state_d = ST_LOAD_A;
      end
      ST_LOAD_B: begin
        bus.in_ready = 1'b1;
        bus.m2EN     = xfer_s;
        bus.m2wEN    = xfer_s;
        bus.addr2    = ADDR_W'(lin_cnt);
        if (lin_wrap) state_d = ST_MAC;
        else          state_d = ST_LOAD_B;
      end
      ST_MAC: begin
        bus.m1EN     = 1'b1;
        bus.m1rEN    = 1'b1;
        bus.m2EN     = 1'b1;
        bus.m2rEN    = 1'b1;
        bus.addr1    = ADDR_W'(i_cnt) * ADDR_W'(N) + ADDR_W'(k_cnt);
        bus.addr2    = ADDR_W'(k_cnt) * ADDR_W'(M) + ADDR_W'(j_cnt);
        bus.mult_rst = (k_cnt == '0);
        if (k_wrap) state_d = ST_DRAIN;
        else        state_d = ST_MAC;
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        bus.m3EN  = 1'b1;
        bus.m3wEN = 1'b1;
        bus.addr3 = ADDR_W'(i_cnt) * ADDR_W'(M) + ADDR_W'(j_cnt);
        if (i_wrap) state_d = ST_READ_C;
        else        state_d = ST_MAC;
      end
      ST_READ_C: begin
        bus.m3EN  = 1'b1;
        bus.m3rEN = 1'b1;
        bus.addr3 = ADDR_W'(lin_cnt);
        if (lin_wrap) state_d = ST_FLUSH;
        else          state_d = ST_READ_C;
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State plus the one-cycle-delayed read strobes that qualify datapath results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mac_rd_q <= 1'b0;
      rd_c_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mac_rd_q <= (state_q == ST_MAC);
      rd_c_q   <= (state_q == ST_READ_C);
      done_q   <= (state_q == ST_READ_C) && lin_wrap;
    end
  end

  assign bus.mult_ld   = mac_rd_q;
  assign bus.out_valid = rd_c_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.shift_cnt = SHIFT_NONE;
endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: two instances (M=2,N=2 and M=2,N=1) each with a small
// memory/accumulator datapath model; results are compared against a plain matrix product.
module tb_matmul_ctrl;
  logic       clk;
  logic       rst;
  logic       start_s    [2];
  logic       in_valid_s [2];
  logic [7:0] din_s      [2];

  wire        in_ready_w [2];
  wire        m1we_w     [2];
  wire        m2we_w     [2];
  wire        m3we_w     [2];
  wire        m3rd_w     [2];
  wire        mrst_w     [2];
  wire        mld_w      [2];
  wire        out_valid_w[2];
  wire        done_w     [2];
  wire        busy_w     [2];
  wire        any_w      [2];
  wire [3:0]  a1_w       [2];
  wire [3:0]  a2_w       [2];
  wire [3:0]  a3_w       [2];
  wire [31:0] acc_w      [2];
  wire [31:0] rdc_w      [2];

  int err_cnt = 0;
  int chk_cnt = 0;
  int a_m [4];
  int b_m [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int NN = (g == 0) ? 2 : 1;
    localparam int AW = 2 + NN;

    matmul_ctrl_if #(.ADDR_W(AW)) bif ();
    matmul_ctrl #(.DATA_WIDTH(8), .M(2), .N(NN), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .bus(bif)
    );

    logic [7:0]  mem_a [1 << AW];
    logic [7:0]  mem_b [1 << AW];
    logic [31:0] mem_c [1 << AW];
    logic [7:0]  rd_a, rd_b;
    logic [31:0] rd_c, acc;

    assign bif.start    = start_s[g];
    assign bif.in_valid = in_valid_s[g];

    always @(posedge clk) begin
      if (bif.m1EN && bif.m1wEN) mem_a[bif.addr1] <= din_s[g];
      if (bif.m1EN && bif.m1rEN) rd_a <= mem_a[bif.addr1];
      if (bif.m2EN && bif.m2wEN) mem_b[bif.addr2] <= din_s[g];
      if (bif.m2EN && bif.m2rEN) rd_b <= mem_b[bif.addr2];
      if (bif.m3EN && bif.m3wEN) mem_c[bif.addr3] <= acc;
      if (bif.m3EN && bif.m3rEN) rd_c <= mem_c[bif.addr3];
      if (bif.mult_rst)     acc <= 32'd0;
      else if (bif.mult_ld) acc <= acc + 32'(rd_a) * 32'(rd_b);
    end

    assign in_ready_w[g]  = bif.in_ready;
    assign m1we_w[g]      = bif.m1EN && bif.m1wEN;
    assign m2we_w[g]      = bif.m2EN && bif.m2wEN;
    assign m3we_w[g]      = bif.m3EN && bif.m3wEN;
    assign m3rd_w[g]      = bif.m3EN && bif.m3rEN;
    assign mrst_w[g]      = bif.mult_rst;
    assign mld_w[g]       = bif.mult_ld;
    assign out_valid_w[g] = bif.out_valid;
    assign done_w[g]      = bif.done;
    assign busy_w[g]      = bif.busy;
    assign a1_w[g]        = 4'(bif.addr1);
    assign a2_w[g]        = 4'(bif.addr2);
    assign a3_w[g]        = 4'(bif.addr3);
    assign acc_w[g]       = acc;
    assign rdc_w[g]       = rd_c;
    assign any_w[g] = bif.in_ready | bif.m1EN | bif.m1rEN | bif.m1wEN | bif.m2EN | bif.m2rEN |
                      bif.m2wEN | bif.m3EN | bif.m3rEN | bif.m3wEN | (|bif.addr1) | (|bif.addr2) |
                      (|bif.addr3) | bif.mult_ld | bif.mult_rst | (|bif.shift_cnt) |
                      bif.out_valid | bif.busy | bif.done;
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One complete job on instance g (M=2, inner dimension n); abort_at>0 fires rst
  // in the given compute cycle instead of finishing.
  task automatic run_job(input int g, input int n, input bit stall, input int abort_at,
                         input bit hold_start);
    int m = 2;
    int total, loaded, outs, ir_cnt, comp, rst_cnt, both, dones, cyc;
    bit finished, aborted, seen_read, xfer;
    int c_ref [4];
    total = 2 * m * n;
    loaded = 0; outs = 0; ir_cnt = 0; comp = 0; rst_cnt = 0; both = 0; dones = 0; cyc = 0;
    finished = 1'b0; aborted = 1'b0; seen_read = 1'b0;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < m; j++) begin
        c_ref[i * m + j] = 0;
        for (int k = 0; k < n; k++) c_ref[i * m + j] += a_m[i * n + k] * b_m[k * m + j];
      end
    end
    while (!finished && !aborted && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start_s[g] = (cyc == 1) || (hold_start && loaded == total && !seen_read);
      if (loaded < total) begin
        in_valid_s[g] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        din_s[g] = 8'((loaded < m * n) ? a_m[loaded] : b_m[loaded - m * n]);
      end else begin
        in_valid_s[g] = 1'b0;
        din_s[g] = 8'd0;
      end
      #1;
      xfer = in_valid_s[g] && in_ready_w[g];
      check_eq("a_wr_en", m1we_w[g], xfer && loaded < m * n);
      check_eq("b_wr_en", m2we_w[g], xfer && loaded >= m * n);
      if (m1we_w[g]) check_eq("a_addr", a1_w[g], loaded);
      if (m2we_w[g]) check_eq("b_addr", a2_w[g], loaded - m * n);
      if (xfer) loaded++;
      if (in_ready_w[g]) ir_cnt++;
      if (m3rd_w[g]) seen_read = 1'b1;
      if (busy_w[g] && !in_ready_w[g] && !m3rd_w[g] && !out_valid_w[g]) comp++;
      if (mrst_w[g]) rst_cnt++;
      if (mrst_w[g] && mld_w[g]) both++;
      if (m3we_w[g]) check_eq("c_write", acc_w[g], c_ref[a3_w[g]]);
      if (out_valid_w[g]) begin
        check_eq("c_out", rdc_w[g], c_ref[outs]);
        check_eq("done_on_last", done_w[g], outs == m * m - 1);
        outs++;
      end
      if (done_w[g]) begin
        dones++;
        finished = 1'b1;
      end
      if (abort_at > 0 && comp == abort_at) begin
        rst = 1'b1;
        start_s[g] = 1'b0;
        in_valid_s[g] = 1'b0;
        #1;
        check_eq("abort_outs", any_w[g], 0);
        check_eq("abort_busy", busy_w[g], 0);
        @(negedge clk);
        #1;
        check_eq("abort_hold", any_w[g], 0);
        rst = 1'b0;
        aborted = 1'b1;
      end
    end
    if (aborted) begin
      check_eq("abort_no_done", dones, 0);
    end else begin
      check_eq("job_done_seen", finished, 1);
      if (!stall) check_eq("in_ready_cycles", ir_cnt, total);
      check_eq("compute_cycles", comp, m * m * (n + 2));
      check_eq("mult_rst_count", rst_cnt, m * m);
      check_eq("rst_ld_overlap", both, 0);
      check_eq("done_count", dones, 1);
      check_eq("out_count", outs, m * m);
    end
    @(negedge clk);
    start_s[g] = 1'b0;
    in_valid_s[g] = 1'b0;
    #1;
    check_eq("idle_after", busy_w[g], 0);
  endtask

  task automatic set_mats(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
    a_m[0] = a0; a_m[1] = a1; a_m[2] = a2; a_m[3] = a3;
    b_m[0] = b0; b_m[1] = b1; b_m[2] = b2; b_m[3] = b3;
  endtask

  task automatic rand_mats();
    for (int i = 0; i < 4; i++) begin
      a_m[i] = int'($urandom_range(0, 255));
      b_m[i] = int'($urandom_range(0, 255));
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0;
      in_valid_s[g] = 1'b0;
      din_s[g] = 8'd0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outs0", any_w[0], 0);
    check_eq("reset_outs1", any_w[1], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("idle_outs0", any_w[0], 0);
    check_eq("idle_outs1", any_w[1], 0);

    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_job(0, 2, 1'b0, 0, 1'b0);
    run_job(0, 2, 1'b1, 0, 1'b0);

    rand_mats();
    run_job(0, 2, 1'b0, 6, 1'b0);
    run_job(0, 2, 1'b0, 0, 1'b0);

    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_job(0, 2, 1'b1, 0, 1'b1);

    set_mats(3, 4, 0, 0, 5, 6, 0, 0);
    run_job(1, 1, 1'b0, 0, 1'b0);

    set_mats(255, 255, 255, 255, 255, 255, 255, 255);
    run_job(0, 2, 1'b0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rand_mats();
      run_job(r % 2, 2 - (r % 2), 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
